prm_xyz_sweep: RTL and testbench

Sweep sequencer that drives the primitive-check datapath from the issuing side. On `start` it walks every (x,y,z) coordinate and presents each one to the checker on `chk_xyz`, with the `sel1`/`sel2` values latched at start. It collects each 32-bit `result_imp` a fixed LAT cycles later and streams `{xyz, result}` records out through a valid/ready port backed by a small FIFO. It sits between the host/control logic and the checker top, replacing hand-driven `xyzInput`.

---
 rtl/prm_pkg.sv | 21 ++
 rtl/prm_sync_fifo.sv | 64 ++++++
 rtl/prm_xyz_sweep.sv | 142 ++++++++++++++
 tb/tb_prm_xyz_sweep.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/prm_pkg.sv
// Shared types and default coordinate widths for the primitive-check sweep path.
package prm_pkg;

    localparam int XW_DEF = 4;
    localparam int YW_DEF = 5;
    localparam int ZW_DEF = 5;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } sweep_state_t;

    typedef struct packed {
        logic [XW_DEF-1:0] x;
        logic [YW_DEF-1:0] y;
        logic [ZW_DEF-1:0] z;
    } prm_xyz_t;

endpackage

// File: rtl/prm_sync_fifo.sv
// Small synchronous FIFO with register-file storage; the head entry is always
// presented on o_rd_data and o_count feeds the issuer's credit check.
module prm_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 46
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    i_wr_en,
    input  logic [W-1:0]            i_wr_data,
    input  logic                    i_rd_en,
    output logic                    o_valid,
    output logic [W-1:0]            o_rd_data,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0]     r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [DEPTH-1:0] w_we;
    logic             w_pop;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
        assign w_we[gi] = i_wr_en && (r_wr_ptr == AW'(gi));
    end

    assign w_pop = i_rd_en && (r_count != '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_mem    <= '{default: '0};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_we[i]) begin
                    r_mem[i] <= i_wr_data;
                end
            end
            if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            // A write and a pop in the same cycle leave occupancy unchanged.
            case ({i_wr_en, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid   = (r_count != '0);
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule

// File: rtl/prm_xyz_sweep.sv
// Sweep sequencer: walks every {x,y,z} coordinate into the checker, captures each
// result LAT cycles after issue and streams {xyz,result} records through a FIFO.
module prm_xyz_sweep
    import prm_pkg::*;
#(
    parameter int XW    = XW_DEF,
    parameter int YW    = YW_DEF,
    parameter int ZW    = ZW_DEF,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic [2:0]          sel1_cfg,
    input  logic [7:0]          sel2_cfg,
    output logic                busy,
    output logic                done,
    output logic [2:0]          chk_sel1,
    output logic [7:0]          chk_sel2,
    output logic [XW+YW+ZW-1:0] chk_xyz,
    input  logic [31:0]         chk_result,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XW+YW+ZW-1:0] out_xyz,
    output logic [31:0]         out_result
);
    localparam int N  = XW + YW + ZW;
    localparam int AW = $clog2(DEPTH);
    localparam logic [N-1:0] XYZ_LAST = '1;
    localparam logic [N-1:0] XYZ_ONE  = {{(N-1){1'b0}}, 1'b1};

    sweep_state_t   r_state;
    sweep_state_t   w_state_next;
    logic [2:0]     r_sel1;
    logic [7:0]     r_sel2;
    logic [N-1:0]   r_xyz;
    logic [LAT-1:0] r_tag_vld;
    logic [N-1:0]   r_tag_xyz [LAT];
    logic [LAT-1:0] w_vld_next;
    logic [N-1:0]   w_xyz_next [LAT];
    logic [15:0]    w_inflight;
    logic [AW:0]    w_fifo_count;
    logic           w_credit_ok;
    logic           w_accept;
    logic           w_issue;
    logic           w_capture;
    logic [N+31:0]  w_head;

    // Tag pipeline: a valid tag marks a cycle whose coordinate must be captured
    // when it reaches the tail; bubbles shift through on stalled cycles.
    assign w_vld_next[0] = w_issue;
    assign w_xyz_next[0] = r_xyz;
    for (genvar gi = 1; gi < LAT; gi++) begin : g_shift
        assign w_vld_next[gi] = r_tag_vld[gi-1];
        assign w_xyz_next[gi] = r_tag_xyz[gi-1];
    end

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            w_inflight = w_inflight + {15'd0, r_tag_vld[i]};
        end
    end

    // Credits cover tags in flight plus FIFO residents, so a capture never sees a full FIFO.
    assign w_credit_ok = (w_inflight + 16'(w_fifo_count)) < 16'(DEPTH);
    assign w_capture   = r_tag_vld[LAT-1];

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (w_credit_ok) begin
                    w_issue = 1'b1;
                    if (r_xyz == XYZ_LAST) begin
                        w_state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((r_tag_vld == '0) && (w_fifo_count == '0)) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_sel1    <= '0;
            r_sel2    <= '0;
            r_xyz     <= '0;
            r_tag_vld <= '0;
            r_tag_xyz <= '{default: '0};
        end else begin
            r_state   <= w_state_next;
            r_tag_vld <= w_vld_next;
            r_tag_xyz <= w_xyz_next;
            if (w_accept) begin
                r_sel1 <= sel1_cfg;
                r_sel2 <= sel2_cfg;
                r_xyz  <= '0;
            end else if (w_issue && (r_xyz != XYZ_LAST)) begin
                r_xyz <= r_xyz + XYZ_ONE;
            end
        end
    end

    prm_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (N + 32)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .i_wr_en   (w_capture),
        .i_wr_data ({r_tag_xyz[LAT-1], chk_result}),
        .i_rd_en   (out_ready),
        .o_valid   (out_valid),
        .o_rd_data (w_head),
        .o_count   (w_fifo_count)
    );

    assign {out_xyz, out_result} = w_head;
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign chk_sel1 = r_sel1;
    assign chk_sel2 = r_sel2;
    assign chk_xyz  = r_xyz;

endmodule

// File: tb/tb_prm_xyz_sweep.sv
// Drives two sweep instances (LAT=2/DEPTH=4 and LAT=1/DEPTH=2) against a checker
// model returning xyz*3, and checks every record, handshake and timing rule.
module tb_prm_xyz_sweep;
    localparam int NW   = 4;
    localparam int DEP0 = 4;
    localparam int DEP1 = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start;
    logic        out_ready;
    logic [2:0]  sel1_cfg;
    logic [7:0]  sel2_cfg;
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [1:0]  out_valid;
    logic [2:0]  chk_sel1 [2];
    logic [7:0]  chk_sel2 [2];
    logic [NW-1:0] chk_xyz [2];
    logic [NW-1:0] out_xyz [2];
    logic [31:0] chk_result [2];
    logic [31:0] out_result [2];
    logic [31:0] pipe0 [2];
    logic [31:0] pipe1;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int rec_idx   [2] = '{0, 0};
    int issued    [2] = '{0, 0};
    int done_cnt  [2] = '{0, 0};
    int start_cyc [2] = '{0, 0};
    logic [NW-1:0] prev_xyz [2];
    logic [NW-1:0] last_xyz [2];
    logic [31:0]   last_res [2];
    logic [2:0]    exp_sel1 [2];
    logic [7:0]    exp_sel2 [2];
    logic          prev_done [2];
    logic          timed = 1'b0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Checker stand-in: result = xyz*3, valid LAT cycles after the coordinate changes.
    always_ff @(posedge CLK) begin
        pipe0[0] <= 32'(chk_xyz[0]) * 32'd3;
        pipe0[1] <= pipe0[0];
        pipe1    <= 32'(chk_xyz[1]) * 32'd3;
    end
    assign chk_result[0] = pipe0[1];
    assign chk_result[1] = pipe1;

    prm_xyz_sweep #(.XW(1), .YW(1), .ZW(2), .LAT(2), .DEPTH(DEP0)) u_dut0 (
        .CLK(CLK), .RST(RST), .start(start), .sel1_cfg(sel1_cfg), .sel2_cfg(sel2_cfg),
        .busy(busy[0]), .done(done[0]), .chk_sel1(chk_sel1[0]), .chk_sel2(chk_sel2[0]),
        .chk_xyz(chk_xyz[0]), .chk_result(chk_result[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready), .out_xyz(out_xyz[0]), .out_result(out_result[0])
    );

    prm_xyz_sweep #(.XW(1), .YW(1), .ZW(2), .LAT(1), .DEPTH(DEP1)) u_dut1 (
        .CLK(CLK), .RST(RST), .start(start), .sel1_cfg(sel1_cfg), .sel2_cfg(sel2_cfg),
        .busy(busy[1]), .done(done[1]), .chk_sel1(chk_sel1[1]), .chk_sel2(chk_sel2[1]),
        .chk_xyz(chk_xyz[1]), .chk_result(chk_result[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready), .out_xyz(out_xyz[1]), .out_result(out_result[1])
    );

    task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (t=%0t)", name, d, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] outs(input int d);
        return {10'd0, busy[d], done[d], out_valid[d], chk_sel1[d], chk_sel2[d],
                chk_xyz[d], out_xyz[d], out_result[d]};
    endfunction

    // Compare process: every cycle, away from the active edge.
    initial begin
        for (int d = 0; d < 2; d++) begin
            prev_xyz[d]  = '0;
            prev_done[d] = 1'b0;
            last_xyz[d]  = '0;
            last_res[d]  = '0;
            exp_sel1[d]  = '0;
            exp_sel2[d]  = '0;
        end
        forever begin
            @(negedge CLK);
            for (int d = 0; d < 2; d++) begin
                if (RST) begin
                    prev_done[d] = 1'b0;
                end else begin
                    if (start && !busy[d]) begin
                        exp_sel1[d]  = sel1_cfg;
                        exp_sel2[d]  = sel2_cfg;
                        rec_idx[d]   = 0;
                        issued[d]    = 0;
                        prev_xyz[d]  = '0;
                        start_cyc[d] = cyc;
                    end
                    if (prev_done[d]) check("busy_drop_after_done", d, 64'(busy[d]), 64'd0);
                    if (busy[d]) begin
                        check("chk_sel", d, {chk_sel1[d], chk_sel2[d]}, {exp_sel1[d], exp_sel2[d]});
                        if (chk_xyz[d] != prev_xyz[d]) begin
                            check("xyz_step", d, 64'(chk_xyz[d]), 64'(prev_xyz[d]) + 64'd1);
                            issued[d]++;
                            prev_xyz[d] = chk_xyz[d];
                        end
                        check("outstanding_le_depth", d,
                              64'((issued[d] - rec_idx[d]) <= ((d == 0) ? DEP0 : DEP1)), 64'd1);
                    end
                    if (out_valid[d] && out_ready) begin
                        check("rec_xyz", d, 64'(out_xyz[d]), 64'(rec_idx[d]));
                        check("rec_result", d, 64'(out_result[d]), 64'(rec_idx[d] * 3));
                        $display("dut%0d record %0d: xyz=%0d result=%0d", d, rec_idx[d], out_xyz[d], out_result[d]);
                        last_xyz[d] = out_xyz[d];
                        last_res[d] = out_result[d];
                        rec_idx[d]++;
                    end
                    if (done[d]) begin
                        check("done_after_all_records", d, 64'(rec_idx[d]), 64'd16);
                        if (d == 0 && timed) check("done_latency", d, 64'(cyc - start_cyc[d]), 64'd21);
                        $display("dut%0d done after %0d cycles", d, cyc - start_cyc[d]);
                        done_cnt[d]++;
                    end
                    prev_done[d] = done[d];
                end
            end
        end
    end

    task automatic pulse_start(input logic [2:0] s1, input logic [7:0] s2);
        @(posedge CLK); #1;
        sel1_cfg = s1;
        sel2_cfg = s2;
        start    = 1'b1;
        @(posedge CLK); #1;
        start    = 1'b0;
        sel1_cfg = 3'd2;
        sel2_cfg = ~s2;
    endtask

    // mode 0: ready high; 1: 20-cycle stall; 2: alternating ready; 3: second start at cycle 5
    task automatic run_sweep(input logic [2:0] s1, input logic [7:0] s2, input int mode);
        int base [2];
        int n;
        base[0] = done_cnt[0];
        base[1] = done_cnt[1];
        timed = (mode == 0 || mode == 3);
        pulse_start(s1, s2);
        n = 0;
        while ((done_cnt[0] == base[0] || done_cnt[1] == base[1]) && n < 400) begin
            if (mode == 1)      out_ready = !(n >= 5 && n < 25);
            else if (mode == 2) out_ready = n[0];
            else                out_ready = 1'b1;
            start = (mode == 3 && n == 4);
            @(posedge CLK); #1;
            n++;
        end
        out_ready = 1'b1;
        start     = 1'b0;
        check("sweep_within_budget", mode, 64'(n < 400), 64'd1);
        for (int d = 0; d < 2; d++) begin
            check("done_pulse_count", d, 64'(done_cnt[d] - base[d]), 64'd1);
            check("record_count", d, 64'(rec_idx[d]), 64'd16);
            check("last_xyz", d, 64'(last_xyz[d]), 64'd15);
            check("last_result", d, 64'(last_res[d]), 64'd45);
        end
    endtask

    task automatic abort_test();
        int base [2];
        int n;
        timed = 1'b0;
        pulse_start(3'd5, 8'hA3);
        n = 0;
        while (rec_idx[0] < 7 && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        check("abort_reached_record7", 0, 64'(n < 100), 64'd1);
        base[0] = done_cnt[0];
        base[1] = done_cnt[1];
        #2;
        RST = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) check("async_reset_outputs", d, outs(d), 64'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("no_done_after_abort", d, 64'(done_cnt[d]), 64'(base[d]));
            check("idle_after_abort", d, 64'(busy[d]), 64'd0);
        end
    endtask

    initial begin
        start     = 1'b0;
        out_ready = 1'b1;
        sel1_cfg  = '0;
        sel2_cfg  = '0;
        RST       = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        for (int d = 0; d < 2; d++) check("reset_outputs", d, outs(d), 64'd0);
        RST = 1'b0;
        run_sweep(3'd5, 8'hA3, 0);
        run_sweep(3'd5, 8'hA3, 1);
        run_sweep(3'd5, 8'h3C, 2);
        run_sweep(3'd5, 8'hA3, 3);
        abort_test();
        run_sweep(3'd6, 8'h5A, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
